demux12_stream: RTL and testbench

- Registered 1-to-2 stream demultiplexer; the counterpart of the 2:1 data mux used in our datapaths.
- Takes one NBITS-wide input stream with a valid/ready handshake.
- Each word is routed by a per-word select to one of two output channels.
- Each output channel has a one-entry holding register, so back-pressure on one output is isolated from the other channel's stored word.

---
 rtl/demux12_stream_if.sv | 26 ++
 rtl/demux12_stream.sv | 93 +++++++++
 tb/tb_demux12_stream.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/demux12_stream_if.sv
// Stream bundle for demux12_stream: one valid/ready input stream and two valid/ready outputs.
// master = producer/consumer environment, slave = the demultiplexer.
interface demux12_stream_if #(
  parameter int unsigned NBITS = 8
);
  logic [NBITS-1:0] di;
  logic             sel;
  logic             di_valid;
  logic             di_ready;
  logic [NBITS-1:0] do0;
  logic             do0_valid;
  logic             do0_ready;
  logic [NBITS-1:0] do1;
  logic             do1_valid;
  logic             do1_ready;

  modport master (
    output di, sel, di_valid, do0_ready, do1_ready,
    input  di_ready, do0, do0_valid, do1, do1_valid
  );

  modport slave (
    input  di, sel, di_valid, do0_ready, do1_ready,
    output di_ready, do0, do0_valid, do1, do1_valid
  );
endinterface

// File: rtl/demux12_stream.sv
// Registered 1-to-2 stream demux with a one-entry holding register per output channel.
// Optional per-channel delivered-word counters (cnt0/cnt1) are enabled by DEMUX12_CNT_EN.
module demux12_stream #(
  parameter int unsigned NBITS = 8
`ifdef DEMUX12_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  demux12_stream_if.slave       bus
`ifdef DEMUX12_CNT_EN
  ,
  output logic [CNT_W-1:0]      cnt0,
  output logic [CNT_W-1:0]      cnt1
`endif
);

  logic [NBITS-1:0] r_do0;
  logic [NBITS-1:0] r_do1;
  logic             r_do0_valid;
  logic             r_do1_valid;

  logic w_free0;
  logic w_free1;
  logic w_ready;
  logic w_load0;
  logic w_load1;
  logic w_drain0;
  logic w_drain1;

  // A channel can take a word if it is empty or its current word leaves this cycle.
  always_comb begin
    w_free0  = !r_do0_valid || bus.do0_ready;
    w_free1  = !r_do1_valid || bus.do1_ready;
    w_ready  = !rst && (bus.sel ? w_free1 : w_free0);
    w_load0  = bus.di_valid && w_ready && !bus.sel;
    w_load1  = bus.di_valid && w_ready && bus.sel;
    w_drain0 = r_do0_valid && bus.do0_ready;
    w_drain1 = r_do1_valid && bus.do1_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_do0       <= '0;
      r_do0_valid <= 1'b0;
    end else if (w_load0) begin
      r_do0       <= bus.di;
      r_do0_valid <= 1'b1;
    end else if (w_drain0) begin
      r_do0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_do1       <= '0;
      r_do1_valid <= 1'b0;
    end else if (w_load1) begin
      r_do1       <= bus.di;
      r_do1_valid <= 1'b1;
    end else if (w_drain1) begin
      r_do1_valid <= 1'b0;
    end
  end

  assign bus.di_ready  = w_ready;
  assign bus.do0       = r_do0;
  assign bus.do0_valid = r_do0_valid;
  assign bus.do1       = r_do1;
  assign bus.do1_valid = r_do1_valid;

`ifdef DEMUX12_CNT_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Counts delivered words; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_drain0) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_drain1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux12_stream.sv
// Self-checking bench for demux12_stream: directed test-plan steps followed by a randomized
// phase checked against a queue-based model of the two single-entry channels.
module tb_demux12_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux12_stream_if #(.NBITS(8)) bus ();

`ifdef DEMUX12_CNT_EN
  logic [3:0] cnt0;
  logic [3:0] cnt1;
  demux12_stream #(.NBITS(8), .CNT_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .cnt0 (cnt0),
    .cnt1 (cnt1)
  );
`else
  demux12_stream #(.NBITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model: each channel is a queue of capacity one; lastN is what the data output shows.
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [7:0]  last0, last1;
  int unsigned mc0, mc1;
  bit          m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_ready();
    bit f0, f1;
    f0 = (q0.size() == 0) || bus.do0_ready;
    f1 = (q1.size() == 0) || bus.do1_ready;
    return !rst && (bus.sel ? f1 : f0);
  endfunction

  // Apply the effect of the clock edge that just happened, using the inputs held across it.
  task automatic model_edge();
    logic [7:0] tmp;
    if (rst) begin
      q0.delete();
      q1.delete();
      last0 = 8'h00;
      last1 = 8'h00;
      mc0   = 0;
      mc1   = 0;
      m_acc = 1'b0;
      return;
    end
    m_acc = bus.di_valid && model_ready();
    if (q0.size() != 0 && bus.do0_ready) begin tmp = q0.pop_front(); mc0++; end
    if (q1.size() != 0 && bus.do1_ready) begin tmp = q1.pop_front(); mc1++; end
    if (m_acc) begin
      if (bus.sel) begin q1.push_back(bus.di); last1 = bus.di; end
      else         begin q0.push_back(bus.di); last0 = bus.di; end
    end
  endtask

  initial begin
    // Reset with a pending word: nothing may be accepted.
    bus.di = 8'hFF; bus.sel = 1'b0; bus.di_valid = 1'b1;
    bus.do0_ready = 1'b1; bus.do1_ready = 1'b1;
    #1;
    chk("rst_di_ready", bus.di_ready, 0);
    step();
    step();
    chk("rst_di_ready2", bus.di_ready, 0);
    chk("rst_do0_valid", bus.do0_valid, 0);
    chk("rst_do1_valid", bus.do1_valid, 0);
    chk("rst_do0", bus.do0, 8'h00);
    chk("rst_do1", bus.do1, 8'h00);
    rst = 1'b0;

    // Basic routing, back-to-back
    bus.di = 8'h01; bus.sel = 1'b0; bus.di_valid = 1'b1;
    #1;
    chk("route_rdy0", bus.di_ready, 1);
    step();
    chk("route_do0", bus.do0, 8'h01);
    chk("route_do0_valid", bus.do0_valid, 1);
    bus.di = 8'h0F; bus.sel = 1'b1;
    #1;
    chk("route_rdy1", bus.di_ready, 1);
    step();
    chk("route_do1", bus.do1, 8'h0F);
    chk("route_do1_valid", bus.do1_valid, 1);
    chk("route_do0_drained", bus.do0_valid, 0);
    bus.di_valid = 1'b0;
    step();
    chk("route_do1_drained", bus.do1_valid, 0);

    // Back-pressure on channel 0
    bus.do0_ready = 1'b0;
    bus.di = 8'hA5; bus.sel = 1'b0; bus.di_valid = 1'b1;
    step();
    chk("bp_do0_a5", bus.do0, 8'hA5);
    chk("bp_do0_valid", bus.do0_valid, 1);
    bus.di = 8'h3C;
    #1;
    chk("bp_stall", bus.di_ready, 0);
    step();
    chk("bp_hold", bus.do0, 8'hA5);
    chk("bp_stall2", bus.di_ready, 0);
    step();
    chk("bp_hold2", bus.do0, 8'hA5);
    bus.do0_ready = 1'b1;
    #1;
    chk("bp_release", bus.di_ready, 1);
    step();
    chk("bp_do0_3c", bus.do0, 8'h3C);
    chk("bp_do0_valid2", bus.do0_valid, 1);

    // Isolation: channel 0 full and blocked, channel 1 still flows
    bus.do0_ready = 1'b0;
    bus.di = 8'h77; bus.sel = 1'b1;
    #1;
    chk("iso_rdy", bus.di_ready, 1);
    step();
    chk("iso_do1", bus.do1, 8'h77);
    chk("iso_do1_valid", bus.do1_valid, 1);
    chk("iso_do0", bus.do0, 8'h3C);
    chk("iso_do0_valid", bus.do0_valid, 1);

    // Same-cycle drain and load on channel 1
    bus.di = 8'h11;
    step();
    chk("dl_do1_11", bus.do1, 8'h11);
    bus.di = 8'h22;
    step();
    chk("dl_do1_22", bus.do1, 8'h22);
    chk("dl_do1_valid", bus.do1_valid, 1);
    bus.di_valid = 1'b0;
    bus.do0_ready = 1'b1;
    step();
    chk("dl_drained0", bus.do0_valid, 0);
    chk("dl_drained1", bus.do1_valid, 0);

`ifdef DEMUX12_CNT_EN
    // Counter wrap at CNT_W=4 and reset clear
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.sel = 1'b0; bus.di_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.di = 8'(i);
      step();
    end
    bus.di_valid = 1'b0;
    step();
    chk("cnt0_wrap", cnt0, 1);
    chk("cnt1_zero", cnt1, 0);
    bus.di_valid = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("cnt0_rst", cnt0, 0);
    chk("cnt1_rst", cnt1, 0);
    chk("cnt_rst_valid", bus.do0_valid, 0);
`endif

    // Randomized traffic against the model
    rst = 1'b1;
    bus.di_valid = 1'b0;
    step();
    model_edge();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      // Producer must hold an unaccepted word stable.
      if (!(bus.di_valid && !m_acc)) begin
        bus.di_valid = ($urandom_range(0, 3) != 0);
        bus.di       = 8'($urandom);
        bus.sel      = 1'($urandom);
      end
      bus.do0_ready = ($urandom_range(0, 2) != 0);
      bus.do1_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_di_ready", bus.di_ready, model_ready());
      step();
      model_edge();
      chk("rnd_do0_valid", bus.do0_valid, q0.size() != 0);
      chk("rnd_do1_valid", bus.do1_valid, q1.size() != 0);
      chk("rnd_do0", bus.do0, last0);
      chk("rnd_do1", bus.do1, last1);
`ifdef DEMUX12_CNT_EN
      chk("rnd_cnt0", cnt0, mc0 % 16);
      chk("rnd_cnt1", cnt1, mc1 % 16);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
